// File: rtl/jk_ctrl_pkg.sv
// Shared constants for the JK bank controller: opcodes, FSM states
// and the J/K pair encodings understood by each cell.
package jk_ctrl_pkg;

   localparam logic [2:0] OP_HOLD = 3'd0;
   localparam logic [2:0] OP_SET  = 3'd1;
   localparam logic [2:0] OP_CLR  = 3'd2;
   localparam logic [2:0] OP_TOG  = 3'd3;
   localparam logic [2:0] OP_LOAD = 3'd4;
   localparam logic [2:0] OP_UP   = 3'd5;
   localparam logic [2:0] OP_DOWN = 3'd6;
   localparam logic [2:0] OP_RSVD = 3'd7;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // {j,k} pairs
   localparam logic [1:0] JK_HOLD = 2'b00;
   localparam logic [1:0] JK_SET  = 2'b10;
   localparam logic [1:0] JK_CLR  = 2'b01;
   localparam logic [1:0] JK_TOG  = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop cell, async active-high reset to 0.
// Ports: clk, rst, j, k in; q out.
module jk_cell
   import jk_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic j,
   input  logic k,
   output logic q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= 1'b0;
      end else begin
         unique case ({j, k})
            JK_SET:  q <= 1'b1;
            JK_CLR:  q <= 1'b0;
            JK_TOG:  q <= ~q;
            default: q <= q;
         endcase
      end
   end

endmodule

// File: rtl/jk_bank_controller.sv
// Command sequencer driving a WIDTH-bit bank of JK cells.
// Ports: clk/rst, cmd_valid/cmd_ready/cmd_op/cmd_data/cmd_count
// handshake, abort, status busy/done/wrap, bank state q and q_b.
module jk_bank_controller
   import jk_ctrl_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             wrap,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_b
);

   state_t           state;
   logic [CNT_W-1:0] rem;
   logic             dir_up;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic             accept;
   logic             is_count;

   // Synchronous counter: a bit toggles when all lower bits are
   // ones (up) or all zeros (down).
   function automatic logic [WIDTH-1:0] step_mask(
      input logic [WIDTH-1:0] v,
      input logic             up
   );
      logic [WIDTH-1:0] t;
      t[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         t[i] = t[i-1] & (up ? v[i-1] : ~v[i-1]);
      end
      return t;
   endfunction

   assign cmd_ready = (state == IDLE);
   assign busy      = (state == RUN);
   assign accept    = cmd_valid && cmd_ready;
   assign is_count  = (cmd_op == OP_UP) || (cmd_op == OP_DOWN);
   assign q_b       = ~q;

   always_comb begin
      j = '0;
      k = '0;
      unique case (state)
         IDLE: begin
            if (cmd_valid) begin
               case (cmd_op)
                  OP_SET: j = cmd_data;
                  OP_CLR: k = cmd_data;
                  OP_TOG: begin
                     j = cmd_data;
                     k = cmd_data;
                  end
                  OP_LOAD: begin
                     j = cmd_data;
                     k = ~cmd_data;
                  end
                  default: ;
               endcase
            end
         end
         RUN: begin
            if (!abort) begin
               j = step_mask(q, dir_up);
               k = step_mask(q, dir_up);
            end
         end
         default: ;
      endcase
   end

   for (genvar b = 0; b < WIDTH; b++) begin : g_cell
      jk_cell u_cell (
         .clk (clk),
         .rst (rst),
         .j   (j[b]),
         .k   (k[b]),
         .q   (q[b])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         rem    <= '0;
         dir_up <= 1'b0;
         done   <= 1'b0;
         wrap   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               done <= 1'b0;
               wrap <= 1'b0;
               if (accept) begin
                  if (is_count && cmd_count != '0) begin
                     state  <= RUN;
                     rem    <= cmd_count;
                     dir_up <= (cmd_op == OP_UP);
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (abort) begin
                  state <= IDLE;
                  rem   <= '0;
                  done  <= 1'b0;
                  wrap  <= 1'b0;
               end else begin
                  rem  <= rem - CNT_W'(1);
                  wrap <= dir_up ? (&q) : ~(|q);
                  if (rem == CNT_W'(1)) begin
                     state <= IDLE;
                     done  <= 1'b1;
                  end else begin
                     done <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jk_bank_controller.sv
// Directed testbench for jk_bank_controller (WIDTH=4, CNT_W=8).
// Each scenario task drives vectors and checks hand-computed results.
module tb_jk_bank_controller;

   localparam int WIDTH = 4;
   localparam int CNT_W = 8;

   logic             clk;
   logic             rst;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [WIDTH-1:0] cmd_data;
   logic [CNT_W-1:0] cmd_count;
   logic             abort;
   logic             busy;
   logic             done;
   logic             wrap;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] q_b;

   int total = 0;
   int bad   = 0;

   jk_bank_controller #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .cmd_count (cmd_count),
      .abort     (abort),
      .busy      (busy),
      .done      (done),
      .wrap      (wrap),
      .q         (q),
      .q_b       (q_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] op,
                        input logic [3:0] data,
                        input logic [7:0] cnt);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      cmd_count = cnt;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cmd_valid = 1'b0;
      cmd_op = 3'd0;
      cmd_data = '0;
      cmd_count = '0;
      abort = 1'b0;
      step();
      step();
      total++;
      if (q !== 4'b0000) begin
         bad++;
         $display("FAIL reset_q got=%b want=0000", q);
      end
      total++;
      if (q_b !== 4'b1111) begin
         bad++;
         $display("FAIL reset_qb got=%b want=1111", q_b);
      end
      total++;
      if ({busy, done, wrap} !== 3'b000) begin
         bad++;
         $display("FAIL reset_flags got=%b want=000", {busy, done, wrap});
      end
      rst = 1'b0;
      #1;
      total++;
      if (cmd_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_ready got=%b want=1", cmd_ready);
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] ops [4];
      logic [3:0] dat [4];
      logic [3:0] exq [4];
      ops = '{3'd1, 3'd3, 3'd2, 3'd4};
      dat = '{4'b0101, 4'b0110, 4'b0001, 4'b1001};
      exq = '{4'b0101, 4'b0011, 4'b0010, 4'b1001};
      for (int i = 0; i < 4; i++) begin
         drive(ops[i], dat[i], 8'd0);
         step();
         total++;
         if (q !== exq[i] || q_b !== ~exq[i]) begin
            bad++;
            $display("FAIL b2b_q[%0d] got=%b/%b want=%b", i, q, q_b, exq[i]);
         end
         total++;
         if (done !== 1'b1 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_done[%0d] got=%b%b want=11", i, done, cmd_ready);
         end
      end
      cmd_valid = 1'b0;
      step();
      total++;
      if (done !== 1'b0) begin
         bad++;
         $display("FAIL b2b_done_drop got=%b want=0", done);
      end
   endtask

   task automatic test_count_up();
      logic [3:0] exq [5];
      logic       exw [5];
      logic       exd [5];
      exq = '{4'b1110, 4'b1111, 4'b0000, 4'b0001, 4'b0010};
      exw = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      exd = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      drive(3'd4, 4'b1101, 8'd0);
      step();
      drive(3'd5, 4'b0000, 8'd5);
      step();
      cmd_valid = 1'b0;
      total++;
      if (q !== 4'b1101 || busy !== 1'b1 || cmd_ready !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL up_accept got q=%b busy=%b rdy=%b done=%b want 1101 1 0 0",
                  q, busy, cmd_ready, done);
      end
      for (int i = 0; i < 5; i++) begin
         step();
         total++;
         if (q !== exq[i] || wrap !== exw[i] || done !== exd[i]) begin
            bad++;
            $display("FAIL up_step[%0d] got q=%b w=%b d=%b want q=%b w=%b d=%b",
                     i, q, wrap, done, exq[i], exw[i], exd[i]);
         end
         total++;
         if (busy !== ~exd[i] || cmd_ready !== exd[i]) begin
            bad++;
            $display("FAIL up_busy[%0d] got busy=%b rdy=%b want busy=%b",
                     i, busy, cmd_ready, ~exd[i]);
         end
      end
      step();
      total++;
      if (done !== 1'b0 || wrap !== 1'b0 || q !== 4'b0010) begin
         bad++;
         $display("FAIL up_after got d=%b w=%b q=%b want 0 0 0010", done, wrap, q);
      end
   endtask

   task automatic test_count_down();
      logic [3:0] exq [3];
      logic       exw [3];
      logic       exd [3];
      exq = '{4'b0000, 4'b1111, 4'b1110};
      exw = '{1'b0, 1'b1, 1'b0};
      exd = '{1'b0, 1'b0, 1'b1};
      drive(3'd4, 4'b0001, 8'd0);
      step();
      drive(3'd6, 4'b0000, 8'd3);
      step();
      cmd_valid = 1'b0;
      total++;
      if (q !== 4'b0001 || busy !== 1'b1) begin
         bad++;
         $display("FAIL dn_accept got q=%b busy=%b want 0001 1", q, busy);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if (q !== exq[i] || wrap !== exw[i] || done !== exd[i]) begin
            bad++;
            $display("FAIL dn_step[%0d] got q=%b w=%b d=%b want q=%b w=%b d=%b",
                     i, q, wrap, done, exq[i], exw[i], exd[i]);
         end
      end
      total++;
      if (q_b !== 4'b0001) begin
         bad++;
         $display("FAIL dn_qb got=%b want=0001", q_b);
      end
   endtask

   task automatic test_abort();
      drive(3'd2, 4'b1111, 8'd0);
      step();
      drive(3'd5, 4'b0000, 8'd10);
      step();
      cmd_valid = 1'b0;
      step();
      step();
      step();
      total++;
      if (q !== 4'b0011 || busy !== 1'b1) begin
         bad++;
         $display("FAIL abort_pre got q=%b busy=%b want 0011 1", q, busy);
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      total++;
      if (q !== 4'b0011 || busy !== 1'b0 || done !== 1'b0 || wrap !== 1'b0) begin
         bad++;
         $display("FAIL abort_edge got q=%b b=%b d=%b w=%b want 0011 0 0 0",
                  q, busy, done, wrap);
      end
      total++;
      if (cmd_ready !== 1'b1) begin
         bad++;
         $display("FAIL abort_ready got=%b want=1", cmd_ready);
      end
      step();
      total++;
      if (done !== 1'b0 || q !== 4'b0011) begin
         bad++;
         $display("FAIL abort_after got d=%b q=%b want 0 0011", done, q);
      end
   endtask

   task automatic test_abort_idle();
      abort = 1'b1;
      drive(3'd5, 4'b0000, 8'd2);
      step();
      abort = 1'b0;
      cmd_valid = 1'b0;
      total++;
      if (busy !== 1'b1 || q !== 4'b0011) begin
         bad++;
         $display("FAIL abort_idle got busy=%b q=%b want 1 0011", busy, q);
      end
      step();
      step();
      total++;
      if (q !== 4'b0101 || done !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL abort_idle_end got q=%b d=%b b=%b want 0101 1 0",
                  q, done, busy);
      end
   endtask

   task automatic test_count_zero();
      drive(3'd5, 4'b1111, 8'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         total++;
         if (q !== 4'b0101 || done !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_cnt[%0d] got q=%b d=%b r=%b b=%b want 0101 1 1 0",
                     i, q, done, cmd_ready, busy);
         end
      end
      cmd_valid = 1'b0;
      step();
   endtask

   task automatic test_reset_mid_run();
      drive(3'd4, 4'b1010, 8'd0);
      step();
      drive(3'd5, 4'b0000, 8'd10);
      step();
      cmd_valid = 1'b0;
      total++;
      if (q !== 4'b1010 || busy !== 1'b1) begin
         bad++;
         $display("FAIL rst_pre got q=%b busy=%b want 1010 1", q, busy);
      end
      #3;
      rst = 1'b1;
      #1;
      total++;
      if (q !== 4'b0000 || q_b !== 4'b1111 || busy !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid got q=%b qb=%b b=%b want 0000 1111 0",
                  q, q_b, busy);
      end
      total++;
      if (cmd_ready !== 1'b1 || done !== 1'b0 || wrap !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid_flags got r=%b d=%b w=%b want 1 0 0",
                  cmd_ready, done, wrap);
      end
      #2;
      rst = 1'b0;
      step();
      total++;
      if (q !== 4'b0000 || done !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL rst_after got q=%b d=%b b=%b want 0000 0 0",
                  q, done, busy);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_count_up();
      test_count_down();
      test_abort();
      test_abort_idle();
      test_count_zero();
      test_reset_mid_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
